// File: rtl/tt_cpu_host_if.sv
// tt_cpu_host_if: program-load and captured-output handshakes of tt_cpu_host
interface tt_cpu_host_if;
  logic       load_valid;
  logic       load_ready;
  logic [5:0] load_data;
  logic       load_last;
  logic       out_valid;
  logic [5:0] out_data;
  logic       out_ready;
  modport master (output load_valid, load_data, load_last, out_ready, input load_ready, out_valid, out_data);
  modport slave (input load_valid, load_data, load_last, out_ready, output load_ready, out_valid, out_data);
endinterface

// File: rtl/tt_cpu_host.sv
// tt_cpu_host: loads a program store, serves CPU memory reads and captures CPU output values into a FIFO
module tt_cpu_host (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    cpu_out,
  output logic [5:0]    cpu_mem_in,
  output logic          cpu_reset,
  input  logic          restart,
  tt_cpu_host_if.slave  bus,
  output logic [2:0]    fifo_count,
  output logic          overflow,
  output logic          running
);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0]  state, state_nx;
  logic [5:0]  wptr;
  logic [63:0] written;
  logic [5:0]  store [64];
  logic        hold_cnt;
  logic        prev_out;
  logic [5:0]  fifo_mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic        xfer, is_out, push, pop, accept;
  assign is_out         = cpu_out[7:6] == 2'b10;
  assign xfer           = bus.load_valid && state == LOAD;
  assign push           = state == RUN && is_out && !prev_out;
  assign pop            = bus.out_valid && bus.out_ready;
  assign accept         = push && (fifo_count != 3'd4 || pop);
  assign running        = state == RUN;
  assign bus.load_ready = state == LOAD;
  assign bus.out_valid  = fifo_count != 3'd0;
  assign bus.out_data   = bus.out_valid ? fifo_mem[rd_ptr] : 6'd0;
  // memory reads are combinational so the CPU sees data in the cycle it presents the address
  assign cpu_mem_in     = (running && cpu_out[7:6] == 2'b00 && written[cpu_out[5:0]]) ? store[cpu_out[5:0]] : 6'd0;
  // next state: restart dominates, LOAD ends on last word or top address, HOLD is two cycles
  always_comb
    state_nx = restart ? LOAD :
               state == LOAD ? ((xfer && (bus.load_last || wptr == 6'd63)) ? HOLD : LOAD) :
               state == HOLD ? (hold_cnt ? RUN : HOLD) : RUN;
  // control state, load pointer, written flags, CPU reset and output edge detector
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= LOAD;
      cpu_reset <= 1'b1;
      wptr      <= 6'd0;
      written   <= '0;
      hold_cnt  <= 1'b0;
      prev_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_reset <= state_nx != RUN;
      hold_cnt  <= state == HOLD && !hold_cnt && !restart;
      prev_out  <= is_out && !restart;
      if (restart) begin
        wptr    <= 6'd0;
        written <= '0;
      end else if (xfer) begin
        written[wptr] <= 1'b1;
        wptr          <= wptr == 6'd63 ? wptr : wptr + 6'd1;
      end
    end
  // capture FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset)
    if (reset || restart) begin
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      fifo_count <= fifo_count + {2'd0, accept} - {2'd0, pop};
      if (push && !accept) overflow <= 1'b1;
    end
  // storage arrays; contents are only trusted through the written flags and FIFO count
  always_ff @(posedge clk) begin
    if (xfer) store[wptr] <= bus.load_data;
    if (accept) fifo_mem[wr_ptr] <= cpu_out[5:0];
  end
endmodule
